// File: rtl/pipe_adder.sv
// Pipelined ripple-chunk adder/subtractor with a valid/ready handshake.
// N bits are split into STAGES chunks of W = N/STAGES bits (N must be a
// multiple of STAGES). Stage k adds chunk k using the carry registered by
// stage k-1. Upper operand chunks ride along until they are consumed, and
// finished low result chunks ride along until the top chunk completes.
// The last stage is the output register. It carries the optional signed
// saturation and the overflow flag, so the latency is exactly STAGES cycles.
// A stalled output (out_valid && !out_ready) freezes every stage at once.
module pipe_adder #(
    parameter int N      = 16,
    parameter int STAGES = 4,
    parameter int SAT    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         Ovf
);

    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    localparam logic signed [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

    // Clamp to the signed range on overflow. The direction follows the sign
    // of A, because an overflow only happens when both operand signs match.
    function automatic logic signed [N-1:0] sat_fn(input logic signed [N-1:0] raw,
                                                   input logic ovf,
                                                   input logic neg);
        if ((SAT != 0) && ovf) begin
            return neg ? SMIN : SMAX;
        end
        return raw;
    endfunction

    logic out_valid_q;
    logic adv;

    // A result held at the output with no taker freezes the whole pipeline.
    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * W;

        logic [N-LO-1:0] a_in;
        logic [N-LO-1:0] b_in;
        logic            c_in;
        logic            v_in;
        logic [W:0]      sum_c;
        logic [LO+W-1:0] res;

        if (k == 0) begin : g_src
            // Subtraction is A + ~B + 1. Cin only matters for addition.
            assign a_in = A;
            assign b_in = sub ? ~B : B;
            assign c_in = sub | Cin;
            assign v_in = in_valid;
            assign res  = sum_c[W-1:0];
        end else begin : g_src
            assign a_in = g_st[k-1].g_reg.a_q;
            assign b_in = g_st[k-1].g_reg.b_q;
            assign c_in = g_st[k-1].g_reg.cry_q;
            assign v_in = g_st[k-1].g_reg.vld_q;
            assign res  = {sum_c[W-1:0], g_st[k-1].g_reg.s_q};
        end

        assign sum_c = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};

        if (k < L) begin : g_reg
            logic              vld_q;
            logic              cry_q;
            logic [LO+W-1:0]   s_q;
            logic [N-LO-W-1:0] a_q;
            logic [N-LO-W-1:0] b_q;

            // Stage valid bit. Reset drops every in-flight operand set.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                end else if (adv) begin
                    vld_q <= v_in;
                end
            end

            // Stage data: chunk carry, finished low bits, unconsumed operand bits.
            always_ff @(posedge clk) begin
                if (adv) begin
                    cry_q <= sum_c[W];
                    s_q   <= res;
                    a_q   <= a_in[N-LO-1:W];
                    b_q   <= b_in[N-LO-1:W];
                end
            end
        end
    end

    // ---- output stage: the top chunk completes here ----
    logic                 a_msb;
    logic                 b_msb;
    logic signed [N-1:0]  raw_d;
    logic signed [N-1:0]  s_d;
    logic                 ovf_d;
    logic                 cout_d;
    logic                 vld_d;
    logic [N-1:0]         s_q;
    logic                 cout_q;
    logic                 ovf_q;

    assign a_msb  = g_st[L].a_in[W-1];
    assign b_msb  = g_st[L].b_in[W-1];
    assign raw_d  = g_st[L].res;
    assign cout_d = g_st[L].sum_c[W];
    assign vld_d  = g_st[L].v_in;
    assign ovf_d  = (a_msb == b_msb) && (raw_d[N-1] != a_msb);
    assign s_d    = sat_fn(raw_d, ovf_d, a_msb);

    // Registered result. It is cleared by reset and held while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= vld_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The module SHALL have parameter N, default 16, giving operand and result width in bits.
REQ-002 The module SHALL have parameter STAGES, default 4, giving the pipeline depth; N SHALL be divisible by STAGES, and chunk width W = N/STAGES.
REQ-003 The module SHALL have parameter SAT, default 0; 1 enables signed saturation of S.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  A, B, Cin and sub are valid this cycle.
REQ-007 in_ready  output  1  the adder accepts an operand set this cycle.
REQ-008 A, B  input  N  operands, two's complement when interpreted signed.
REQ-009 Cin  input  1  carry-in; used only when sub=0.
REQ-010 sub  input  1  0 computes A+B+Cin; 1 computes A-B (A + ~B + 1).
REQ-011 out_valid  output  1  S, Cout and Ovf hold a result.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 S  output  N  sum or difference, saturated when SAT=1.
REQ-014 Cout  output  1  raw carry out of bit N-1; on subtraction, 0 means borrow.
REQ-015 Ovf  output  1  signed overflow of the unsaturated result.

Function
REQ-016 The input handshake SHALL complete when in_valid && in_ready; the output handshake SHALL complete when out_valid && out_ready.
REQ-017 Stall SHALL be global: stall = out_valid && !out_ready; in_ready = !stall; while stalled, all pipeline registers and outputs SHALL hold.
REQ-018 Stage k (k = 0..STAGES-1) SHALL add bits [k*W+W-1 : k*W] of A and B', where B' is B when sub=0 and ~B when sub=1, with its carry-in taken from the registered carry of stage k-1.
REQ-019 The stage-0 carry-in SHALL be Cin when sub=0 and 1 when sub=1.
REQ-020 Unconsumed operand chunks SHALL be delay-registered alongside each stage, and completed lower chunks SHALL be delay-registered so that all N result bits emerge aligned.
REQ-021 Latency SHALL be exactly STAGES cycles from an accepted input to out_valid for that result, absent stalls; each stall cycle adds one cycle.
REQ-022 Throughput SHALL be one result per cycle with no bubbles when out_ready=1 continuously.
REQ-023 Results SHALL leave in acceptance order; no accepted input SHALL be lost or duplicated.
REQ-024 A valid bit SHALL travel with each stage; when no input is accepted, a bubble (valid=0) SHALL propagate.
REQ-025 Ovf SHALL be 1 iff the operand MSBs (A[N-1] and B'[N-1]) are equal and the raw result MSB differs from them.
REQ-026 With SAT=1 and Ovf=1, S SHALL be 2^(N-1)-1 when A[N-1]=0 and -2^(N-1) when A[N-1]=1; Cout SHALL stay raw.
REQ-027 With SAT=0, S SHALL be the raw result modulo 2^N.
REQ-028 S, Cout and Ovf SHALL be registered outputs, with no combinational path from any input to them.
REQ-029 in_ready SHALL depend only on out_valid and out_ready.
REQ-030 The STAGES=1 case SHALL be supported as a single registered N-bit adder with latency 1.

Reset
REQ-031 While rst=1, all stage valid bits, out_valid, S, Cout and Ovf SHALL be 0, and in_ready SHALL be 1.
REQ-032 Reset asserted mid-operation SHALL discard every in-flight result; the first out_valid after reset release SHALL belong to an input accepted after release.
REQ-033 Input acceptance on the first clock edge after rst deasserts SHALL be honoured.

Verification
REQ-034 With N=16, STAGES=4, SAT=0, in one cycle drive A=0x0FFF, B=0x0001, sub=0, Cin=0 -> exactly 4 cycles later S=0x1000, Cout=0, Ovf=0.
REQ-035 Drive A=0x7FFF, B=0x0001 -> SAT=0 gives S=0x8000, Ovf=1, Cout=0; SAT=1 gives S=0x7FFF, Ovf=1.
REQ-036 Drive sub=1, A=0x0005, B=0x0007 -> S=0xFFFE, Cout=0, Ovf=0; sub=1, A=0x8000, B=0x0001 with SAT=1 -> S=0x8000, Ovf=1.
REQ-037 Drive A=0xFFFF, B=0x0000, Cin=1, sub=0 -> S=0x0000, Cout=1, Ovf=0.
REQ-038 Drive 8 back-to-back random inputs with out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, all 8 results match a reference model in order, with no loss.
REQ-039 Assert rst for 1 cycle with 3 results in flight -> out_valid=0 immediately; the next input accepted after release appears 4 cycles later as the first valid result.
